// File: rtl/output_layer_mac.sv
// Output layer of the digit classifier: ten parallel saturating MACs over N_IN
// streamed activations plus a bias word, producing offset-binary class scores.
module output_layer_mac #(
    parameter int N_IN       = 64,
    parameter int IN_WIDTH   = 16,
    parameter int W_WIDTH    = 16,
    parameter int FRAC_BITS  = 8,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   act_addr,
    input  logic [IN_WIDTH-1:0]     act_data,
    output logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [10*W_WIDTH-1:0]   w_data,
    output logic [10*WIDTH-1:0]     scores,
    output logic                    done,
    output logic                    busy
);

    localparam int NCLS = 10;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_IN);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    vld;
    logic [WIDTH-1:0]        a_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (cnt == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address counter and the one-cycle valid/index pipeline tracking read latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            rd_en <= 1'b0;
            vld   <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt   <= '0;
                rd_en <= 1'b1;
            end else if (state == READ) begin
                if (cnt == LAST) rd_en <= 1'b0;
                else             cnt   <= cnt + 1'b1;
            end
            vld  <= rd_en;
            idx  <= cnt;
            done <= (state == OUT);
        end
    end

    assign busy     = (state != IDLE);
    assign act_addr = cnt;
    assign w_addr   = cnt;
    assign a_ext    = {{(WIDTH-IN_WIDTH){act_data[IN_WIDTH-1]}}, act_data};

    for (genvar k = 0; k < NCLS; k++) begin : g_cls
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] acc_sat;
        logic [WIDTH-1:0] w_ext;
        logic [WIDTH-1:0] term;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] score_q;

        // Operands are pre-extended to WIDTH, so the low WIDTH product bits equal the signed product
        always_comb begin
            w_ext = {{(WIDTH-W_WIDTH){w_data[k*W_WIDTH+W_WIDTH-1]}},
                     w_data[k*W_WIDTH +: W_WIDTH]};
            term  = (idx == LAST) ? (w_ext << FRAC_BITS) : (a_ext * w_ext);
            sum   = {acc[WIDTH-1], acc} + {term[WIDTH-1], term};
            if (sum[WIDTH] != sum[WIDTH-1])
                acc_sat = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
            else
                acc_sat = sum[WIDTH-1:0];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc     <= '0;
                score_q <= '0;
            end else begin
                if (state == IDLE && start) acc <= '0;
                else if (vld)               acc <= acc_sat;
                if (state == OUT) score_q <= {~acc[WIDTH-1], acc[WIDTH-2:0]};
            end
        end

        assign scores[k*WIDTH +: WIDTH] = score_q;
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Randomised and directed checks of output_layer_mac against an arithmetic
// reference model of the ten saturating dot products.
module tb_output_layer_mac;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int WW = 16;
    localparam int FB = 8;
    localparam int W  = 32;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            rd_en;
    logic [AW-1:0]   act_addr;
    logic [IW-1:0]   act_data;
    logic [AW-1:0]   w_addr;
    logic [10*WW-1:0] w_data;
    logic [10*W-1:0] scores;
    logic            done;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [15:0]  act_mem [8];
    logic [159:0] w_mem   [8];
    logic [319:0] last_exp;

    always #5 clk = ~clk;

    output_layer_mac #(
        .N_IN(N), .IN_WIDTH(IW), .W_WIDTH(WW), .FRAC_BITS(FB),
        .WIDTH(W), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en),
        .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr),
        .w_data(w_data), .scores(scores), .done(done), .busy(busy)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            act_data <= act_mem[act_addr];
            w_data   <= w_mem[w_addr];
        end
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [319:0] model();
        logic [319:0] r;
        longint a;
        r = '0;
        for (int k = 0; k < 10; k++) begin
            a = 0;
            for (int i = 0; i < N; i++)
                a = sat(a + longint'($signed(act_mem[i])) * longint'($signed(w_mem[i][k*16 +: 16])));
            a = sat(a + longint'($signed(w_mem[N][k*16 +: 16])) * 256);
            r[k*32 +: 32] = 32'(a) ^ 32'h8000_0000;
        end
        return r;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = '0;
            w_mem[i]   = '0;
        end
    endtask

    task automatic set_w(input int i, input int k, input int v);
        w_mem[i][k*16 +: 16] = v[15:0];
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = 16'($urandom);
            w_mem[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string tag, input bit pulse);
        logic [319:0] exp;
        int lat;
        int rds;
        exp = model();
        lat = 0;
        rds = int'(rd_en);
        while (done !== 1'b1 && lat < 40) begin
            start = pulse && (lat == 2);
            @(negedge clk);
            lat++;
            rds += int'(rd_en);
            if (lat == 3) check({tag, "_hold"}, scores, last_exp);
        end
        start = 1'b0;
        check({tag, "_lat"},    lat, N + 3);
        check({tag, "_rden"},   rds, N + 1);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_scores"}, scores, exp);
        last_exp = exp;
    endtask

    initial begin
        int am;
        int dseen;
        reset    = 1'b0;
        start    = 1'b1;
        last_exp = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_scores", scores, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rden", rd_en, 0);
        check("rst_aaddr", act_addr, 0);
        check("rst_waddr", w_addr, 0);
        start = 1'b0;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_rden", rd_en, 0);
            check("idle_busy", busy, 0);
        end

        // Basic dot product with a bias on class 3
        clear_mem();
        act_mem[0] = 16'd256;
        act_mem[1] = 16'd512;
        act_mem[2] = 16'd0;
        act_mem[3] = 16'hFF00;
        for (int i = 0; i < N; i++) set_w(i, 0, 1);
        set_w(0, 3, 2);
        set_w(N, 3, 1);
        launch();
        wait_done("basic", 1'b0);
        check("basic_s0", scores[31:0],   32'h8000_0200);
        check("basic_s3", scores[127:96], 32'h8000_0300);
        check("basic_s5", scores[191:160], 32'h8000_0000);
        @(negedge clk);
        check("done_pulse", done, 0);

        // Negative values must order correctly after the MSB flip
        clear_mem();
        act_mem[0] = 16'd1;
        set_w(0, 0, -5);
        set_w(0, 1, -3);
        set_w(0, 2, 2);
        launch();
        wait_done("neg", 1'b0);
        check("neg_s0", scores[31:0],  32'h7FFF_FFFB);
        check("neg_s1", scores[63:32], 32'h7FFF_FFFD);
        check("neg_s2", scores[95:64], 32'h8000_0002);
        am = 0;
        for (int k = 1; k < 10; k++)
            if (scores[k*32 +: 32] > scores[am*32 +: 32]) am = k;
        check("neg_argmax", am, 2);
        @(negedge clk);

        // Positive and negative saturation; busy-time start pulses are ignored
        for (int i = 0; i < 8; i++) begin
            act_mem[i] = 16'h7FFF;
            w_mem[i]   = {10{16'h7FFF}};
        end
        launch();
        wait_done("satp", 1'b1);
        check("satp_all", scores, {10{32'hFFFF_FFFF}});
        for (int i = 0; i < 8; i++) w_mem[i] = {10{16'h8000}};
        @(negedge clk);
        launch();
        wait_done("satn", 1'b1);
        check("satn_all", scores, {10{32'h0000_0000}});
        @(negedge clk);

        // Back-to-back random runs, each started in the previous done cycle
        for (int r = 0; r < 5; r++) begin
            rand_mem();
            launch();
            wait_done("rand", r[0]);
        end
        repeat (6) begin
            @(negedge clk);
            check("post_busy", busy, 0);
        end

        // Reset in the middle of a run
        rand_mem();
        launch();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rden", rd_en, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_scores", scores, 0);
        @(negedge clk);
        reset    = 1'b1;
        last_exp = '0;
        dseen    = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || rd_en === 1'b1) dseen++;
        end
        check("mid_quiet", dseen, 0);
        rand_mem();
        launch();
        wait_done("fresh", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
